// File: rtl/approx_add_pipe.sv
// approx_add_pipe: two-stage pipelined unsigned approximate adder (exact / LOA / truncate)
// with a shadow exact adder driving an on-line error monitor (count, error count, error sum, worst error).
module approx_add_pipe #(
    parameter int W    = 8,
    parameter int K    = 4,
    parameter int CNTW = 16,
    parameter int ACCW = 24
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    input  logic [1:0]      MODE,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [W:0]      O,
    output logic [W:0]      ERR,
    input  logic            STAT_CLR,
    output logic [CNTW-1:0] STAT_N,
    output logic [CNTW-1:0] STAT_NERR,
    output logic [ACCW-1:0] STAT_SUM,
    output logic [W:0]      STAT_MAX
);

    // LOW_MASK covers the approximated bits; TOP_BIT is their MSB (zero when K = 0)
    localparam logic [W:0]      LOW_MASK = ~({(W+1){1'b1}} << K);
    localparam logic [W:0]      TOP_BIT  = LOW_MASK ^ (LOW_MASK >> 1);
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [ACCW-1:0] ACC_MAX  = {ACCW{1'b1}};

    function automatic logic [W:0] approx_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] mode);
        logic [W:0] a_x;
        logic [W:0] b_x;
        logic [W:0] upper;
        logic [W:0] res;
        logic       carry;
        a_x   = {1'b0, a};
        b_x   = {1'b0, b};
        carry = |(a_x & b_x & TOP_BIT);
        upper = {(W+1){1'b0}};
        case (mode)
            2'd1: begin
                upper = (a_x >> K) + (b_x >> K) + {{W{1'b0}}, carry};
                res   = (upper << K) | ((a_x | b_x) & LOW_MASK);
            end
            2'd2: begin
                upper = (a_x >> K) + (b_x >> K);
                res   = (upper << K) | TOP_BIT;
            end
            default: res = a_x + b_x;
        endcase
        return res;
    endfunction

    function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    logic            s1_v_r;
    logic [W-1:0]    s1_a_r;
    logic [W-1:0]    s1_b_r;
    logic [1:0]      s1_mode_r;
    logic            out_v_r;
    logic [W:0]      o_r;
    logic [W:0]      err_r;
    logic [CNTW-1:0] stat_n_r;
    logic [CNTW-1:0] stat_nerr_r;
    logic [ACCW-1:0] stat_sum_r;
    logic [W:0]      stat_max_r;

    logic            s2_load_s;
    logic            in_ready_s;
    logic            s1_load_s;
    logic            deliver_s;
    logic [W:0]      exact_s;
    logic [W:0]      approx_s;
    logic [W:0]      err_s;
    logic [CNTW-1:0] stat_n_nx_s;
    logic [CNTW-1:0] stat_nerr_nx_s;
    logic [ACCW-1:0] stat_sum_nx_s;
    logic [W:0]      stat_max_nx_s;
    logic [ACCW:0]   sum_wide_s;

    assign s2_load_s  = s1_v_r & (~out_v_r | OUT_READY);
    assign in_ready_s = ~s1_v_r | s2_load_s;
    assign s1_load_s  = IN_VALID & in_ready_s;
    assign deliver_s  = out_v_r & OUT_READY;
    assign exact_s    = {1'b0, s1_a_r} + {1'b0, s1_b_r};
    assign approx_s   = approx_sum(s1_a_r, s1_b_r, s1_mode_r);
    assign err_s      = abs_diff(exact_s, approx_s);

    // Stage 1: operand and mode capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v_r    <= 1'b0;
            s1_a_r    <= {W{1'b0}};
            s1_b_r    <= {W{1'b0}};
            s1_mode_r <= 2'd0;
        end else begin
            if (s1_load_s) begin
                s1_v_r    <= 1'b1;
                s1_a_r    <= A;
                s1_b_r    <= B;
                s1_mode_r <= MODE;
            end else if (s2_load_s) begin
                s1_v_r <= 1'b0;
            end
        end
    end

    // Stage 2: approximate result and its error, held while the consumer stalls
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_v_r <= 1'b0;
            o_r     <= {(W+1){1'b0}};
            err_r   <= {(W+1){1'b0}};
        end else begin
            if (s2_load_s) begin
                out_v_r <= 1'b1;
                o_r     <= approx_s;
                err_r   <= err_s;
            end else if (OUT_READY) begin
                out_v_r <= 1'b0;
            end
        end
    end

    // Saturating next values of the statistics for a delivered result
    always_comb begin
        stat_n_nx_s    = stat_n_r;
        stat_nerr_nx_s = stat_nerr_r;
        stat_sum_nx_s  = stat_sum_r;
        stat_max_nx_s  = stat_max_r;
        sum_wide_s     = {1'b0, stat_sum_r} + {{(ACCW-W){1'b0}}, err_r};
        if (stat_n_r != CNT_MAX) begin
            stat_n_nx_s = stat_n_r + CNT_ONE;
        end else begin
            stat_n_nx_s = stat_n_r;
        end
        if ((err_r != {(W+1){1'b0}}) && (stat_nerr_r != CNT_MAX)) begin
            stat_nerr_nx_s = stat_nerr_r + CNT_ONE;
        end else begin
            stat_nerr_nx_s = stat_nerr_r;
        end
        if (sum_wide_s[ACCW]) begin
            stat_sum_nx_s = ACC_MAX;
        end else begin
            stat_sum_nx_s = sum_wide_s[ACCW-1:0];
        end
        if (err_r > stat_max_r) begin
            stat_max_nx_s = err_r;
        end else begin
            stat_max_nx_s = stat_max_r;
        end
    end

    // Statistics registers; a clear overrides a coincident delivery
    always_ff @(posedge CLK) begin
        if (RST || STAT_CLR) begin
            stat_n_r    <= {CNTW{1'b0}};
            stat_nerr_r <= {CNTW{1'b0}};
            stat_sum_r  <= {ACCW{1'b0}};
            stat_max_r  <= {(W+1){1'b0}};
        end else if (deliver_s) begin
            stat_n_r    <= stat_n_nx_s;
            stat_nerr_r <= stat_nerr_nx_s;
            stat_sum_r  <= stat_sum_nx_s;
            stat_max_r  <= stat_max_nx_s;
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_v_r;
    assign O         = o_r;
    assign ERR       = err_r;
    assign STAT_N    = stat_n_r;
    assign STAT_NERR = stat_nerr_r;
    assign STAT_SUM  = stat_sum_r;
    assign STAT_MAX  = stat_max_r;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench for approx_add_pipe: directed vector table, streaming scoreboard,
// backpressure, statistics (incl. CNTW=4 saturation) and mid-stream reset.
module tb_approx_add_pipe;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, stat_clr;
    logic [7:0] a, b;
    logic [1:0] mode;
    logic       in_ready, out_valid;
    logic [8:0] o, err, stat_max;
    logic [15:0] stat_n, stat_nerr;
    logic [23:0] stat_sum;
    logic       in_ready4, out_valid4;
    logic [8:0] o4, err4, stat_max4;
    logic [3:0] stat_n4, stat_nerr4;
    logic [23:0] stat_sum4;

    always #5 clk = ~clk;

    approx_add_pipe #(.W(8), .K(4), .CNTW(16), .ACCW(24)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .A(a), .B(b), .MODE(mode),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .O(o), .ERR(err), .STAT_CLR(stat_clr),
        .STAT_N(stat_n), .STAT_NERR(stat_nerr), .STAT_SUM(stat_sum), .STAT_MAX(stat_max));

    approx_add_pipe #(.W(8), .K(4), .CNTW(4), .ACCW(24)) dut4 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready4), .A(a), .B(b), .MODE(mode),
        .OUT_VALID(out_valid4), .OUT_READY(out_ready), .O(o4), .ERR(err4), .STAT_CLR(stat_clr),
        .STAT_N(stat_n4), .STAT_NERR(stat_nerr4), .STAT_SUM(stat_sum4), .STAT_MAX(stat_max4));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        logic [8:0] o;
        logic [8:0] err;
    } vec_t;

    vec_t        vecs[7];
    int          errors = 0;
    int          checks = 0;
    int          delivered = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;
    bit          done;

    // Reference: K=4 on W=8 written out with explicit slices; returns {O, ERR}
    function automatic logic [17:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [1:0] mm);
        logic [8:0] ex;
        logic [8:0] ap;
        logic [4:0] hi;
        ex = {1'b0, ma} + {1'b0, mb};
        ap = ex;
        if (mm == 2'd1) begin
            hi = {1'b0, ma[7:4]} + {1'b0, mb[7:4]} + {4'd0, ma[3] & mb[3]};
            ap = {hi, ma[3:0] | mb[3:0]};
        end else if (mm == 2'd2) begin
            hi = {1'b0, ma[7:4]} + {1'b0, mb[7:4]};
            ap = {hi, 4'b1000};
        end
        return {ap, (ex > ap) ? (ex - ap) : (ap - ex)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Scoreboard: every delivery is compared in order against the model of accepted beats
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got O=0x%0h with nothing outstanding", o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_O", {23'd0, o}, {23'd0, mon_e[17:9]});
                    chk("stream_ERR", {23'd0, err}, {23'd0, mon_e[8:0]});
                end
                delivered++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, mode));
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] tm);
        bit acc;
        int n;
        n = 0;
        a = ta; b = tb_v; mode = tm; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_latency(input string tag);
        a = 8'h12; b = 8'h34; mode = 2'd0; in_valid = 1'b1;
        @(negedge clk); chk({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); chk({tag, "_valid_t1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk); chk({tag, "_valid_t2"}, {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_stats(input string tag, input int n, input int nerr, input int sum, input int mx);
        chk({tag, "_N"}, {16'd0, stat_n}, n);
        chk({tag, "_NERR"}, {16'd0, stat_nerr}, nerr);
        chk({tag, "_SUM"}, {8'd0, stat_sum}, sum);
        chk({tag, "_MAX"}, {23'd0, stat_max}, mx);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0] ho, he;
        int d0;
        bit got;
        vecs[0] = '{8'h37, 8'h2C, 2'd0, 9'h063, 9'd0};
        vecs[1] = '{8'h37, 8'h2C, 2'd1, 9'h05F, 9'd4};
        vecs[2] = '{8'h37, 8'h2C, 2'd2, 9'h058, 9'd11};
        vecs[3] = '{8'h37, 8'h2C, 2'd3, 9'h063, 9'd0};
        vecs[4] = '{8'hFF, 8'hFF, 2'd0, 9'h1FE, 9'd0};
        vecs[5] = '{8'hFF, 8'hFF, 2'd1, 9'h1FF, 9'd1};
        vecs[6] = '{8'hFF, 8'hFF, 2'd2, 9'h1E8, 9'd22};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
        a = 8'd0; b = 8'd0; mode = 2'd0;
        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_O", {23'd0, o}, 32'd0);
        chk("rst_ERR", {23'd0, err}, 32'd0);
        check_stats("rst", 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed mode / carry-out table
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].mode);
            in_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    got = 1'b1;
                    chk($sformatf("vec%0d_O", i), {23'd0, o}, {23'd0, vecs[i].o});
                    chk($sformatf("vec%0d_ERR", i), {23'd0, err}, {23'd0, vecs[i].err});
                end
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL vec%0d_timeout: out_valid stayed 0, expected 1", i);
            end
            @(posedge clk); #1;
        end

        // Latency, then 100 back-to-back beats
        check_latency("lat");
        drain();
        d0 = delivered;
        for (int i = 0; i < 100; i++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
        in_valid = 1'b0;
        chk("stream_throughput", delivered - d0, 98);
        drain();
        chk("stream_count", delivered - d0, 100);

        // Backpressure window of 5 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 12; i++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
                in_valid = 1'b0;
            end
            begin
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                ho = o; he = err;
                repeat (3) @(negedge clk);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_O_stable", {23'd0, o}, {23'd0, ho});
                chk("bp_ERR_stable", {23'd0, err}, {23'd0, he});
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random OUT_READY pattern
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Statistics over modes 0,1,2
        stat_clr = 1'b1; @(posedge clk); #1; stat_clr = 1'b0;
        check_stats("clr", 0, 0, 0, 0);
        send(8'h37, 8'h2C, 2'd0);
        send(8'h37, 8'h2C, 2'd1);
        send(8'h37, 8'h2C, 2'd2);
        in_valid = 1'b0;
        drain();
        @(posedge clk); #1;
        check_stats("stat3", 3, 2, 15, 11);

        // Clear coinciding with a delivery
        send(8'hFF, 8'hFF, 2'd2);
        in_valid = 1'b0;
        for (int n = 0; n < 10 && !out_valid; n++) begin @(posedge clk); #1; end
        chk("clrdel_setup", {31'd0, out_valid}, 32'd1);
        stat_clr = 1'b1; @(posedge clk); #1; stat_clr = 1'b0;
        check_stats("clrdel", 0, 0, 0, 0);
        @(posedge clk); #1;
        check_stats("clrdel_after", 0, 0, 0, 0);

        // Saturation of the CNTW=4 instance
        stat_clr = 1'b1; @(posedge clk); #1; stat_clr = 1'b0;
        for (int i = 0; i < 20; i++) send(8'h37, 8'h2C, 2'd1);
        in_valid = 1'b0;
        drain();
        @(posedge clk); #1;
        check_stats("stat20", 20, 20, 80, 4);
        chk("sat_N4", {28'd0, stat_n4}, 32'd15);
        chk("sat_NERR4", {28'd0, stat_nerr4}, 32'd15);
        chk("sat_SUM4", {8'd0, stat_sum4}, 32'd80);
        chk("sat_MAX4", {23'd0, stat_max4}, 32'd4);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(8'h11, 8'h22, 2'd0);
        send(8'h33, 8'h44, 2'd1);
        in_valid = 1'b0;
        chk("mid_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_stats("mid_rst", 0, 0, 0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_idle%0d", i), {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        check_latency("post_rst");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/approx_add_pipe.md
Name: approx_add_pipe

Overview:
Parametrised, pipelined unsigned approximate adder with a per-transaction runtime mode: exact, lower-part-OR (LOA) or constant-truncated lower part. A shadow exact adder feeds an on-line error monitor that accumulates sample count, erroneous-result count, sum of absolute error and worst-case error, for in-system MAE/WCE/EP characterisation. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
W, 8, operand width in bits (W >= 2)
K, 4, number of approximated low bits (0..W); K=0 makes every mode exact
CNTW, 16, width of the sample and error-count statistics
ACCW, 24, width of the absolute-error accumulator

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
IN_VALID  in  1  operand beat valid
IN_READY  out  1  block can accept an operand beat
A  in  W  operand A
B  in  W  operand B
MODE  in  2  0 exact, 1 LOA, 2 truncate, 3 treated as exact
OUT_VALID  out  1  result valid
OUT_READY  in  1  consumer accepts the result
O  out  W+1  approximate sum
ERR  out  W+1  |exact - O| for the current result
STAT_CLR  in  1  synchronous clear of all statistics
STAT_N  out  CNTW  results delivered (saturating)
STAT_NERR  out  CNTW  delivered results with ERR != 0 (saturating)
STAT_SUM  out  ACCW  sum of ERR over delivered results (saturating)
STAT_MAX  out  W+1  maximum ERR delivered

Behaviour:
- Interface: one clock domain (CLK); RST is synchronous and active-high.
- Reset: all stage-valid flags, OUT_VALID, O, ERR and all STAT_* outputs are 0. IN_READY is 1 in the cycle after RST deasserts. Reset mid-operation drops any in-flight beats silently.
- Handshake: an input beat is accepted when IN_VALID & IN_READY; a result is delivered when OUT_VALID & OUT_READY. While OUT_VALID=1 and OUT_READY=0, O and ERR hold stable.
- Pipeline: 2 stages.
  - S1 registers A, B and MODE.
  - S2 computes and registers O, ERR and the exact sum.
  - A stage loads when it is empty or its contents move downstream in the same cycle.
  - IN_READY = !S1v | (S2 loads this cycle); it is combinational from OUT_READY.
  - Latency: a beat accepted at cycle t gives OUT_VALID at t+2 with no backpressure.
  - Throughput: 1 beat/cycle sustained. The block holds at most 2 beats; no beat is lost or duplicated under any OUT_READY pattern.
- Arithmetic: L = low K bits, U = bits W-1..K.
  - Exact: O = A + B, W+1 bits.
  - LOA:
    - O[K-1:0] = A_L | B_L.
    - Carry into U = A[K-1] & B[K-1].
    - O[W:K] = A_U + B_U + carry.
  - Truncate:
    - O[K-1:0] = 2^(K-1), i.e. MSB of L set, rest 0.
    - No carry into U; O[W:K] = A_U + B_U.
  - K=W: U is empty; O[W] = carry (LOA) or 0 (truncate).
  - K=0: every mode equals exact.
  - ERR = |exact - O|, W+1 bits. The exact sum is always computed in parallel.
- Statistics: update only on a result-delivery cycle, in the cycle after delivery.
  - STAT_N += 1.
  - STAT_NERR += (ERR != 0).
  - STAT_SUM += ERR.
  - STAT_MAX = max(STAT_MAX, ERR).
  - All counters saturate at all-ones and do not wrap.
- STAT_CLR: zeroes all STAT_* next cycle. If it coincides with a delivery, the clear wins and that result is not counted. It does not affect the pipeline.
- MODE is captured per beat. Mixed modes in flight are legal, and each result uses its own captured mode.

Test Plan:
- Mode/arithmetic check, W=8, K=4, A=0x37, B=0x2C (exact result 0x063), one beat per mode:
  - MODE=0 -> O=0x063, ERR=0.
  - MODE=1 -> O=0x05F, ERR=4.
  - MODE=2 -> O=0x058, ERR=11.
  - MODE=3 -> O=0x063, ERR=0.
- Carry-out, A=B=0xFF:
  - MODE=0 -> O=0x1FE, ERR=0.
  - MODE=1 -> O=0x1FF, ERR=1.
  - MODE=2 -> O=0x1E8, ERR=22.
- Throughput and latency: 100 back-to-back random beats, OUT_READY=1 -> first OUT_VALID two cycles after the first accept, then one result per cycle in order. The bench's 2-bit-exact model matches every O/ERR.
- Backpressure: OUT_READY held low for 5 cycles mid-stream -> IN_READY falls after 2 beats are held, O/ERR stay stable, no loss or duplication after release. Then a random OUT_READY toggle run (bench drives OUT_READY as a random pattern) against the model.
- Statistics: the three mode-check beats with MODE 0,1,2 -> STAT_N=3, STAT_NERR=2, STAT_SUM=15, STAT_MAX=11. STAT_CLR asserted on the same cycle as a delivery -> all STAT_* = 0 afterwards. Run CNTW=4 for 20 beats -> STAT_N = 15, saturated.
- Reset mid-stream: assert RST with 2 beats in flight -> OUT_VALID=0 and all STAT_*=0 next cycle, nothing delivered afterwards, and a new beat after reset follows the 2-cycle latency.
